// File: rtl/booth_pkg.sv
// Shared types and Booth recoding for the parametrised sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ZERO,
    OP_ADD1,
    OP_ADD2,
    OP_SUB1,
    OP_SUB2
  } op_e;

  // triplet = {Q[1], Q[0], q_1}; radix-2 only looks at the low pair.
  function automatic op_e booth_recode(input logic [2:0] triplet, input logic r4);
    op_e op;
    op = OP_ZERO;
    if (r4) begin
      case (triplet)
        3'b001, 3'b010: op = OP_ADD1;
        3'b011:         op = OP_ADD2;
        3'b100:         op = OP_SUB2;
        3'b101, 3'b110: op = OP_SUB1;
        default:        op = OP_ZERO;
      endcase
    end else begin
      case (triplet[1:0])
        2'b01:   op = OP_ADD1;
        2'b10:   op = OP_SUB1;
        default: op = OP_ZERO;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/booth_mult_ctrl.sv
// Sequencer for the Booth multiplier: IDLE/CALC/DONE state and iteration count.
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mode_r4,
  output logic busy,
  output logic load_c,
  output logic iter_c,
  output logic finish_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] K_R2 = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] K_R4 = CNT_W'(WIDTH / 2);

  state_e           state;
  logic [CNT_W-1:0] cnt;

  // Strobes are combinational so the datapath captures operands on the accept edge.
  assign load_c   = (state == IDLE) && start;
  assign iter_c   = (state == CALC);
  assign finish_c = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            cnt   <= mode_r4 ? K_R4 : K_R2;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/booth_mult_param.sv
// Sequential signed Booth multiplier, radix-2 or radix-4 selectable per operation.
module booth_mult_param
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode_r4,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned SW = AW + WIDTH + 1;

  logic [AW-1:0]        acc;
  logic [AW-1:0]        m_ext;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        acc_sum;
  logic [WIDTH-1:0]     q;
  logic                 q_1;
  logic                 r4;
  op_e                  op;
  logic signed [SW-1:0] cat_s;
  logic signed [SW-1:0] shifted_s;
  logic                 load_c;
  logic                 iter_c;
  logic                 finish_c;

  booth_mult_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode_r4  (mode_r4),
    .busy     (busy),
    .load_c   (load_c),
    .iter_c   (iter_c),
    .finish_c (finish_c)
  );

  // One Booth step: add the recoded multiple, then arithmetic shift {A,Q,q_1}.
  always_comb begin
    op     = booth_recode({q[1], q[0], q_1}, r4);
    addend = '0;
    case (op)
      OP_ADD1: addend = m_ext;
      OP_ADD2: addend = m_ext << 1;
      OP_SUB1: addend = -m_ext;
      OP_SUB2: addend = -(m_ext << 1);
      default: addend = '0;
    endcase
    acc_sum   = acc + addend;
    cat_s     = {acc_sum, q, q_1};
    shifted_s = r4 ? (cat_s >>> 2) : (cat_s >>> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      m_ext <= '0;
      r4    <= 1'b0;
    end else if (load_c) begin
      acc   <= '0;
      q     <= multiplier;
      q_1   <= 1'b0;
      m_ext <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
      r4    <= mode_r4;
    end else if (iter_c) begin
      {acc, q, q_1} <= shifted_s;
    end
  end

  // Guard bits of A are dropped; the product lives in the low 2*WIDTH bits of {A,Q}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= finish_c;
      if (finish_c) begin
        product <= {acc[WIDTH-1:0], q};
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_param.sv
// Self-checking bench for booth_mult_param at WIDTH 8, 16 and 32.
module tb_booth_mult_param;

  logic clk;
  logic rst_n;

  logic        start8,  mode8,  busy8,  done8;
  logic [7:0]  mc8,  mp8;
  logic [15:0] prod8;

  logic        start16, mode16, busy16, done16;
  logic [15:0] mc16, mp16;
  logic [31:0] prod16;

  logic        start32, mode32, busy32, done32;
  logic [31:0] mc32, mp32;
  logic [63:0] prod32;

  int errors;
  int checks;

  booth_mult_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode_r4(mode8),
    .multiplicand(mc8), .multiplier(mp8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  booth_mult_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode_r4(mode16),
    .multiplicand(mc16), .multiplier(mp16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  booth_mult_param #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .mode_r4(mode32),
    .multiplicand(mc32), .multiplier(mp32),
    .busy(busy32), .done(done32), .product(prod32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed multiply truncated to 2*16 bits.
  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b);
    return 32'(longint'($signed(a)) * longint'($signed(b)));
  endfunction

  // Stimulus only: one WIDTH=16 operation, reports first done latency, product and done count.
  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic r4,
                         output logic [31:0] p, output int lat, output int ndone);
    int k;
    k = r4 ? 8 : 16;
    start16 = 1'b1; mode16 = r4; mc16 = a; mp16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; mc16 = $urandom; mp16 = $urandom; mode16 = ~r4;
    lat = -1; ndone = 0; p = 'x;
    for (int n = 1; n <= k + 6; n++) begin
      @(posedge clk); #1;
      if (done16) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          p   = prod16;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 0; start16 = 0; start32 = 0;
    mode8 = 0; mode16 = 0; mode32 = 0;
    mc8 = 0; mp8 = 0; mc16 = 0; mp16 = 0; mc32 = 0; mp32 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy16); end
    checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done16); end
    checks++; if (prod16 !== 32'h0) begin errors++; $display("FAIL reset_product got=%h want=0", prod16); end
    checks++; if (prod32 !== 64'h0 || prod8 !== 16'h0) begin
      errors++; $display("FAIL reset_product_w8_w32 got=%h/%h want=0/0", prod8, prod32);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] p;
    int lat, nd;
    for (int md = 0; md < 2; md++) begin
      do_op16(16'd32, 16'hFFF4, md[0], p, lat, nd);
      checks++; if (p !== 32'hFFFFFE80) begin errors++; $display("FAIL basic_product mode=%0d got=%h want=FFFFFE80", md, p); end
      checks++; if (lat != (md ? 9 : 17)) begin errors++; $display("FAIL basic_latency mode=%0d got=%0d want=%0d", md, lat, md ? 9 : 17); end
      checks++; if (nd != 1) begin errors++; $display("FAIL basic_done_count mode=%0d got=%0d want=1", md, nd); end
    end
  endtask

  task automatic test_corners();
    logic [31:0] p;
    int lat, nd;
    for (int md = 0; md < 2; md++) begin
      do_op16(16'h8000, 16'h8000, md[0], p, lat, nd);
      checks++; if (p !== 32'h40000000) begin errors++; $display("FAIL min_x_min mode=%0d got=%h want=40000000", md, p); end
      do_op16(16'h8000, 16'h7FFF, md[0], p, lat, nd);
      checks++; if (p !== 32'hC0008000) begin errors++; $display("FAIL min_x_max mode=%0d got=%h want=C0008000", md, p); end
      checks++; if (lat != (md ? 9 : 17)) begin errors++; $display("FAIL corner_latency mode=%0d got=%0d want=%0d", md, lat, md ? 9 : 17); end
    end
  endtask

  // First op radix-2 with A; B and radix-4 applied during CALC with start held.
  task automatic test_start_held();
    logic [15:0] a_m, a_q, b_m, b_q;
    logic [31:0] got_p [2];
    int          got_t [2];
    int          nd;
    logic        busy_n1, busy_n17;
    a_m = 16'd100; a_q = 16'hFFF9; b_m = 16'hFFFB; b_q = 16'd321;
    nd = 0; busy_n1 = 1'bx; busy_n17 = 1'bx;
    got_p[0] = 'x; got_p[1] = 'x; got_t[0] = -1; got_t[1] = -1;
    start16 = 1'b1; mode16 = 1'b0; mc16 = a_m; mp16 = a_q;
    @(posedge clk); #1;
    mc16 = b_m; mp16 = b_q; mode16 = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk); #1;
      if (n == 1) busy_n1 = busy16;
      if (n == 17) busy_n17 = busy16;
      if (n == 18) start16 = 1'b0;
      if (done16) begin
        if (nd < 2) begin got_p[nd] = prod16; got_t[nd] = n; end
        nd++;
      end
    end
    checks++; if (busy_n1 !== 1'b1) begin errors++; $display("FAIL held_busy_rise got=%b want=1", busy_n1); end
    checks++; if (busy_n17 !== 1'b0) begin errors++; $display("FAIL held_busy_fall got=%b want=0", busy_n17); end
    checks++; if (nd != 2) begin errors++; $display("FAIL held_done_count got=%0d want=2", nd); end
    checks++; if (got_t[0] != 17 || got_p[0] !== ref16(a_m, a_q)) begin
      errors++; $display("FAIL held_first t=%0d p=%h want t=17 p=%h", got_t[0], got_p[0], ref16(a_m, a_q));
    end
    checks++; if (got_t[1] != 27 || got_p[1] !== ref16(b_m, b_q)) begin
      errors++; $display("FAIL held_second t=%0d p=%h want t=27 p=%h", got_t[1], got_p[1], ref16(b_m, b_q));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    int lat, nd;
    int late_done;
    start16 = 1'b1; mode16 = 1'b0; mc16 = 16'd1234; mp16 = 16'hFF9D;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b want=0", busy16); end
    checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL midreset_done got=%b want=0", done16); end
    checks++; if (prod16 !== 32'h0) begin errors++; $display("FAIL midreset_product got=%h want=0", prod16); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    late_done = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done16 || busy16) late_done++;
    end
    checks++; if (late_done != 0) begin errors++; $display("FAIL midreset_stale_activity got=%0d want=0", late_done); end
    do_op16(16'd1234, 16'd567, 1'b1, p, lat, nd);
    checks++; if (p !== ref16(16'd1234, 16'd567) || lat != 9) begin
      errors++; $display("FAIL midreset_fresh p=%h lat=%0d want p=%h lat=9", p, lat, ref16(16'd1234, 16'd567));
    end
  endtask

  task automatic test_random_w8();
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [7:0]  a, b;
        logic [15:0] expv, got;
        int          k, lat;
        a = 8'($urandom); b = 8'($urandom);
        if (i == 0) begin a = 8'h80; b = 8'h80; end
        if (i == 1) begin a = 8'h80; b = 8'h7F; end
        expv = 16'(longint'($signed(a)) * longint'($signed(b)));
        k = md ? 4 : 8;
        start8 = 1'b1; mode8 = md[0]; mc8 = a; mp8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; mc8 = 8'($urandom); mp8 = 8'($urandom); mode8 = 1'($urandom);
        lat = -1; got = 'x;
        for (int n = 1; n <= k + 2; n++) begin
          @(posedge clk); #1;
          if (done8 && lat < 0) begin lat = n; got = prod8; end
        end
        checks++;
        if (got !== expv || lat != k + 1) begin
          errors++;
          $display("FAIL rand_w8 mode=%0d a=%h b=%h got=%h lat=%0d want=%h lat=%0d", md, a, b, got, lat, expv, k + 1);
        end
      end
    end
  endtask

  task automatic test_random_w32();
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [31:0] a, b;
        logic [63:0] expv, got;
        int          k, lat;
        a = $urandom; b = $urandom;
        if (i == 0) begin a = 32'h80000000; b = 32'h80000000; end
        if (i == 1) begin a = 32'h7FFFFFFF; b = 32'h80000000; end
        expv = 64'(longint'($signed(a)) * longint'($signed(b)));
        k = md ? 16 : 32;
        start32 = 1'b1; mode32 = md[0]; mc32 = a; mp32 = b;
        @(posedge clk); #1;
        start32 = 1'b0; mc32 = $urandom; mp32 = $urandom; mode32 = 1'($urandom);
        lat = -1; got = 'x;
        for (int n = 1; n <= k + 2; n++) begin
          @(posedge clk); #1;
          if (done32 && lat < 0) begin lat = n; got = prod32; end
        end
        checks++;
        if (got !== expv || lat != k + 1) begin
          errors++;
          $display("FAIL rand_w32 mode=%0d a=%h b=%h got=%h lat=%0d want=%h lat=%0d", md, a, b, got, lat, expv, k + 1);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_corners();
    test_start_held();
    test_reset_mid();
    fork
      test_random_w8();
      test_random_w32();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
